// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller:
// cell marks, winner codes, board shape, win lines and controller states.
package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam logic [3:0] LAST_CELL = 4'd8;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } mark_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_X    = 2'b01;
    localparam logic [1:0] WINNER_O    = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    // Cell i of the board lives in bits [2*i+1 : 2*i].
    typedef logic [NUM_CELLS-1:0][1:0] board_t;

    // Rows, columns, then the two diagonals.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD_CELL,
        CHK_CELL,
        WR_CELL,
        SCAN,
        EVAL,
        GAME_OVER
    } ctrl_state_t;

    function automatic logic [1:0] toggle_mark(input logic [1:0] m);
        return (m == X) ? O : X;
    endfunction

endpackage

// File: rtl/ttt_if.sv
// Move handshake, game status and board-memory bus of the game controller.
// The timeout_forfeit signal exists only when TTT_MOVE_TIMEOUT_EN is defined.
interface ttt_if;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_addr;
    logic       move_ready;
    logic       move_done;
    logic       move_reject;
    logic [1:0] turn;
    logic       game_over;
    logic [1:0] winner;
    logic       busy;
    logic       mem_r_w;
    logic [3:0] mem_address;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
`ifdef TTT_MOVE_TIMEOUT_EN
    logic       timeout_forfeit;
`endif

    modport master (
        input  new_game, move_valid, move_addr, mem_rdata,
        output move_ready, move_done, move_reject, turn, game_over, winner, busy,
               mem_r_w, mem_address, mem_wdata
`ifdef TTT_MOVE_TIMEOUT_EN
        , output timeout_forfeit
`endif
    );

    modport slave (
        output new_game, move_valid, move_addr, mem_rdata,
        input  move_ready, move_done, move_reject, turn, game_over, winner, busy,
               mem_r_w, mem_address, mem_wdata
`ifdef TTT_MOVE_TIMEOUT_EN
        , input timeout_forfeit
`endif
    );
endinterface

// File: rtl/ttt_win_eval.sv
// Combinational board judge: reports the first completed line of X or O
// and whether every cell is occupied (reserved code 11 counts as occupied).
module ttt_win_eval
    import ttt_pkg::*;
(
    input  board_t     board,
    output logic       win,
    output logic [1:0] win_mark,
    output logic       full
);

    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;

    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        win      = 1'b0;
        win_mark = WINNER_NONE;
        full     = 1'b1;
        a        = EMPTY;
        b        = EMPTY;
        c        = EMPTY;
        for (int l = 0; l < 8; l++) begin
            a = board[WIN_LINES[l[2:0]][0]];
            b = board[WIN_LINES[l[2:0]][1]];
            c = board[WIN_LINES[l[2:0]][2]];
            if (!win && (a == X || a == O) && a == b && b == c) begin
                win      = 1'b1;
                win_mark = a;
            end
        end
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (board[i[3:0]] == EMPTY) full = 1'b0;
        end
    end

endmodule

// File: rtl/ttt_game_controller.sv
// Tic-tac-toe sequencer and sole owner of the 9-cell board memory.
// Optional idle-move forfeit is built when TTT_MOVE_TIMEOUT_EN is defined.
module ttt_game_controller
    import ttt_pkg::*;
#(
    parameter logic [1:0] FIRST_MARK = 2'b01
`ifdef TTT_MOVE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
`endif
) (
    input logic   clk,
    input logic   reset,
    ttt_if.master bus
);

    ctrl_state_t state;
    ctrl_state_t next_state;

    logic [3:0] count;
    logic [3:0] addr_q;
    logic [1:0] turn_q;
    logic [1:0] winner_q;
    logic       game_over_q;
    logic       done_q;
    logic       reject_q;
    logic       accept;
    board_t     shadow;

    logic       win;
    logic [1:0] win_mark;
    logic       full;

    ttt_win_eval u_win_eval (
        .board    (shadow),
        .win      (win),
        .win_mark (win_mark),
        .full     (full)
    );

    assign bus.move_ready  = (state == IDLE) && !bus.new_game;
    assign bus.busy        = (state != IDLE) && (state != GAME_OVER);
    assign bus.move_done   = done_q;
    assign bus.move_reject = reject_q;
    assign bus.turn        = turn_q;
    assign bus.winner      = winner_q;
    assign bus.game_over   = game_over_q;
    assign accept          = bus.move_ready && bus.move_valid;

    // Next state and memory bus; the bus idles as a read of cell 0.
    always_comb begin
        next_state      = state;
        bus.mem_r_w     = 1'b1;
        bus.mem_address = 4'd0;
        bus.mem_wdata   = 2'b00;
        case (state)
            CLEAR: begin
                bus.mem_r_w     = 1'b0;
                bus.mem_address = count;
                if (count == LAST_CELL) next_state = IDLE;
            end
            IDLE: begin
                if (bus.new_game)        next_state = CLEAR;
                else if (bus.move_valid) next_state = RD_CELL;
            end
            RD_CELL: begin
                bus.mem_address = addr_q;
                next_state      = (addr_q > LAST_CELL) ? IDLE : CHK_CELL;
            end
            CHK_CELL: begin
                next_state = (bus.mem_rdata != EMPTY) ? IDLE : WR_CELL;
            end
            WR_CELL: begin
                bus.mem_r_w     = 1'b0;
                bus.mem_address = addr_q;
                bus.mem_wdata   = turn_q;
                next_state      = SCAN;
            end
            SCAN: begin
                // Reads go out on counts 0..8; count 9 only collects the last read.
                if (count <= LAST_CELL) bus.mem_address = count;
                if (count == 4'd9)      next_state = EVAL;
            end
            EVAL: begin
                next_state = (win || full) ? GAME_OVER : IDLE;
            end
            GAME_OVER: begin
                if (bus.new_game) next_state = CLEAR;
            end
            default: next_state = CLEAR;
        endcase
    end

`ifdef TTT_MOVE_TIMEOUT_EN
    logic [31:0] idle_count;
    logic        forfeit;
    logic        forfeit_q;

    // Staying in IDLE means neither new_game nor move_valid, so a move always beats the forfeit.
    assign forfeit             = (state == IDLE) && (next_state == IDLE) &&
                                 (idle_count == TIMEOUT_CYCLES - 1);
    assign bus.timeout_forfeit = forfeit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_count <= '0;
            forfeit_q  <= 1'b0;
        end else begin
            forfeit_q <= forfeit;
            if (state != IDLE || next_state != IDLE || forfeit) idle_count <= '0;
            else                                                idle_count <= idle_count + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CLEAR;
            count       <= 4'd0;
            addr_q      <= 4'd0;
            turn_q      <= FIRST_MARK;
            winner_q    <= WINNER_NONE;
            game_over_q <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            state    <= next_state;
            done_q   <= (state == EVAL);
            reject_q <= (state == RD_CELL && addr_q > LAST_CELL) ||
                        (state == CHK_CELL && bus.mem_rdata != EMPTY);

            if (next_state != state)                  count <= 4'd0;
            else if (state == CLEAR || state == SCAN) count <= count + 4'd1;

            if (accept) addr_q <= bus.move_addr;

            if (next_state == CLEAR) begin
                turn_q      <= FIRST_MARK;
                winner_q    <= WINNER_NONE;
                game_over_q <= 1'b0;
            end else if (state == EVAL) begin
                if (win) begin
                    winner_q    <= win_mark;
                    game_over_q <= 1'b1;
                end else if (full) begin
                    winner_q    <= WINNER_DRAW;
                    game_over_q <= 1'b1;
                end else begin
                    turn_q <= toggle_mark(turn_q);
                end
            end
`ifdef TTT_MOVE_TIMEOUT_EN
            else if (forfeit) begin
                turn_q <= toggle_mark(turn_q);
            end
`endif
        end
    end

    // NOTE: the shadow board is deliberately not reset; SCAN rewrites all nine cells before EVAL reads them.
    always_ff @(posedge clk) begin
        if (state == SCAN && count != 4'd0) shadow[count - 4'd1] <= bus.mem_rdata;
    end

endmodule

// File: tb/tb_ttt_game_controller.sv
// Directed self-checking bench for ttt_game_controller with a registered-read board memory model.
module tb_ttt_game_controller;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    typedef struct packed {
        logic [3:0] addr;
        logic [1:0] data;
    } wr_t;

    ttt_if bus ();

    ttt_game_controller #(.FIRST_MARK(2'b01)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Board memory: registered read, write on the edge ending a r_w=0 cycle; starts as garbage.
    logic [1:0] mem [16] = '{default: 2'b11};
    wr_t        wq [$];

    always @(posedge clk) begin
        if (!bus.mem_r_w) mem[bus.mem_address] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_address];
        if (reset && !bus.mem_r_w) wq.push_back('{addr: bus.mem_address, data: bus.mem_wdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit clear_seq_ok();
        if (wq.size() != 9) return 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (wq[i].addr != 4'(i) || wq[i].data != 2'b00) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit board_empty();
        for (int i = 0; i < 9; i++) begin
            if (mem[i] != 2'b00) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_ready(input string tag, output int cycles);
        cycles = 0;
        while (bus.move_ready !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (bus.move_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout: move_ready=%b after %0d cycles, required 1", tag, bus.move_ready, cycles);
        end
    endtask

    // Offers one move; reports the cycle (counted from the accept edge) of move_done / move_reject.
    task automatic do_move(input logic [3:0] addr, input int ng_at,
                           output int done_n, output int rej_n, output int writes);
        int base;
        int w;
        done_n = 0;
        rej_n  = 0;
        wait_ready("do_move", w);
        bus.move_valid = 1'b1;
        bus.move_addr  = addr;
        base = wq.size();
        @(negedge clk);
        bus.move_valid = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (bus.move_done === 1'b1)   done_n = n;
            if (bus.move_reject === 1'b1) rej_n  = n;
            if (done_n != 0 || rej_n != 0) break;
            bus.new_game = (n == ng_at);
            @(negedge clk);
        end
        bus.new_game = 1'b0;
        writes = wq.size() - base;
    endtask

    task automatic start_new_game(input string tag);
        int w;
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        wq.delete();
        wait_ready(tag, w);
        checks++;
        if (!clear_seq_ok() || !board_empty() || bus.turn !== 2'b01 || bus.winner !== 2'b00 || bus.game_over !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: writes=%0d board_empty=%b turn=%b winner=%b game_over=%b, required 9/1/01/00/0",
                     tag, wq.size(), board_empty(), bus.turn, bus.winner, bus.game_over);
        end
    endtask

    task automatic play_game(input logic [3:0] cells [9], input int len, input string tag);
        int done_n, rej_n, writes;
        logic [1:0] exp_turn;
        for (int i = 0; i < len; i++) begin
            do_move(cells[i], 0, done_n, rej_n, writes);
            checks++;
            if (done_n != 15 || rej_n != 0 || writes != 1) begin
                errors++;
                $display("FAIL %s move%0d: done_cycle=%0d reject_cycle=%0d writes=%0d, required 15/0/1",
                         tag, i, done_n, rej_n, writes);
            end
            if (i < len - 1) begin
                exp_turn = (i % 2 == 0) ? 2'b10 : 2'b01;
                checks++;
                if (bus.turn !== exp_turn || bus.game_over !== 1'b0) begin
                    errors++;
                    $display("FAIL %s move%0d_turn: turn=%b game_over=%b, required %b/0",
                             tag, i, bus.turn, bus.game_over, exp_turn);
                end
            end
        end
    endtask

    task automatic test_reset();
        int w;
        bus.new_game   = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_addr  = 4'd0;
        reset          = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.move_ready !== 1'b0 || bus.turn !== 2'b01 || bus.winner !== 2'b00 ||
            bus.game_over !== 1'b0 || bus.move_done !== 1'b0 || bus.move_reject !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: busy=%b ready=%b turn=%b winner=%b game_over=%b done=%b reject=%b, required 1/0/01/00/0/0/0",
                     bus.busy, bus.move_ready, bus.turn, bus.winner, bus.game_over, bus.move_done, bus.move_reject);
        end
        reset = 1'b1;
        wq.delete();
        wait_ready("reset", w);
        checks++;
        if (w != 9) begin
            errors++;
            $display("FAIL reset_clear_cycles: ready after %0d cycles, required 9", w);
        end
        checks++;
        if (!clear_seq_ok() || !board_empty() || bus.turn !== 2'b01 || bus.winner !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear: writes=%0d board_empty=%b turn=%b winner=%b busy=%b, required 9/1/01/00/0",
                     wq.size(), board_empty(), bus.turn, bus.winner, bus.busy);
        end
    endtask

    task automatic test_first_move();
        int done_n, rej_n, writes;
        // new_game pulsed mid-move must be ignored.
        do_move(4'd4, 5, done_n, rej_n, writes);
        checks++;
        if (done_n != 15 || rej_n != 0) begin
            errors++;
            $display("FAIL first_move_timing: done_cycle=%0d reject_cycle=%0d, required 15/0", done_n, rej_n);
        end
        checks++;
        if (writes != 1 || wq[wq.size()-1].addr !== 4'd4 || wq[wq.size()-1].data !== 2'b01 || mem[4] !== 2'b01) begin
            errors++;
            $display("FAIL first_move_write: writes=%0d mem4=%b, required 1 write of 01 at 4", writes, mem[4]);
        end
        checks++;
        if (bus.turn !== 2'b10 || bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin
            errors++;
            $display("FAIL first_move_status: turn=%b game_over=%b winner=%b, required 10/0/00",
                     bus.turn, bus.game_over, bus.winner);
        end
    endtask

    task automatic test_reject_occupied();
        int done_n, rej_n, writes;
        do_move(4'd4, 0, done_n, rej_n, writes);
        checks++;
        if (rej_n != 3 || done_n != 0 || writes != 0) begin
            errors++;
            $display("FAIL reject_occupied: reject_cycle=%0d done_cycle=%0d writes=%0d, required 3/0/0", rej_n, done_n, writes);
        end
        @(negedge clk);
        checks++;
        if (bus.move_reject !== 1'b0 || bus.turn !== 2'b10 || mem[4] !== 2'b01) begin
            errors++;
            $display("FAIL reject_occupied_after: reject=%b turn=%b mem4=%b, required 0/10/01", bus.move_reject, bus.turn, mem[4]);
        end
    endtask

    task automatic test_reject_range();
        int done_n, rej_n, writes;
        do_move(4'd9, 0, done_n, rej_n, writes);
        checks++;
        if (rej_n != 2 || done_n != 0 || writes != 0 || bus.turn !== 2'b10) begin
            errors++;
            $display("FAIL reject_range: reject_cycle=%0d done_cycle=%0d writes=%0d turn=%b, required 2/0/0/10",
                     rej_n, done_n, writes, bus.turn);
        end
    endtask

    task automatic test_new_game_priority();
        int w;
        wait_ready("priority", w);
        bus.new_game   = 1'b1;
        bus.move_valid = 1'b1;
        bus.move_addr  = 4'd0;
        #1;
        checks++;
        if (bus.move_ready !== 1'b0) begin
            errors++;
            $display("FAIL priority_ready: move_ready=%b with new_game high, required 0", bus.move_ready);
        end
        @(negedge clk);
        bus.new_game   = 1'b0;
        bus.move_valid = 1'b0;
        wq.delete();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL priority_clear_entry: busy=%b, required 1", bus.busy);
        end
        wait_ready("priority", w);
        checks++;
        if (!clear_seq_ok() || !board_empty() || bus.turn !== 2'b01) begin
            errors++;
            $display("FAIL priority_clear: writes=%0d board_empty=%b turn=%b, required 9/1/01", wq.size(), board_empty(), bus.turn);
        end
    endtask

    task automatic test_win();
        int base;
        bit saw_done;
        play_game('{4'd0, 4'd3, 4'd1, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0}, 5, "win");
        checks++;
        if (bus.winner !== 2'b01 || bus.game_over !== 1'b1 || bus.move_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL win_status: winner=%b game_over=%b ready=%b busy=%b, required 01/1/0/0",
                     bus.winner, bus.game_over, bus.move_ready, bus.busy);
        end
        base     = wq.size();
        saw_done = 1'b0;
        bus.move_valid = 1'b1;
        bus.move_addr  = 4'd5;
        repeat (20) begin
            @(negedge clk);
            if (bus.move_done === 1'b1 || bus.move_reject === 1'b1) saw_done = 1'b1;
        end
        bus.move_valid = 1'b0;
        checks++;
        if (wq.size() != base || saw_done || bus.winner !== 2'b01 || bus.busy !== 1'b0 || mem[5] !== 2'b00) begin
            errors++;
            $display("FAIL game_over_ignore: writes=%0d pulse=%b winner=%b busy=%b mem5=%b, required 0/0/01/0/00",
                     wq.size() - base, saw_done, bus.winner, bus.busy, mem[5]);
        end
    endtask

    task automatic test_draw();
        start_new_game("draw");
        play_game('{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8}, 9, "draw");
        checks++;
        if (bus.winner !== 2'b11 || bus.game_over !== 1'b1) begin
            errors++;
            $display("FAIL draw_status: winner=%b game_over=%b, required 11/1", bus.winner, bus.game_over);
        end
    endtask

    task automatic test_win_on_full();
        start_new_game("winfull");
        play_game('{4'd4, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd0, 4'd5, 4'd8}, 9, "winfull");
        checks++;
        if (bus.winner !== 2'b01 || bus.game_over !== 1'b1) begin
            errors++;
            $display("FAIL win_on_full: winner=%b game_over=%b, required 01/1", bus.winner, bus.game_over);
        end
    endtask

    task automatic test_reset_mid_scan();
        int done_n, rej_n, writes, w;
        start_new_game("midscan");
        do_move(4'd4, 0, done_n, rej_n, writes);
        wait_ready("midscan", w);
        bus.move_valid = 1'b1;
        bus.move_addr  = 4'd0;
        @(negedge clk);
        bus.move_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.move_ready !== 1'b0 || bus.turn !== 2'b01 || bus.winner !== 2'b00 ||
            bus.game_over !== 1'b0 || bus.move_done !== 1'b0 || bus.mem_r_w !== 1'b0 || bus.mem_address !== 4'd0) begin
            errors++;
            $display("FAIL midscan_reset: busy=%b ready=%b turn=%b winner=%b game_over=%b done=%b r_w=%b addr=%0d, required 1/0/01/00/0/0/0/0",
                     bus.busy, bus.move_ready, bus.turn, bus.winner, bus.game_over, bus.move_done, bus.mem_r_w, bus.mem_address);
        end
        checks++;
        if (mem[0] !== 2'b10) begin
            errors++;
            $display("FAIL midscan_prewrite: mem0=%b, required 10", mem[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        wq.delete();
        wait_ready("midscan", w);
        checks++;
        if (!clear_seq_ok() || !board_empty() || w != 9) begin
            errors++;
            $display("FAIL midscan_reclear: writes=%0d board_empty=%b cycles=%0d, required 9/1/9", wq.size(), board_empty(), w);
        end
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_reject_occupied();
        test_reject_range();
        test_new_game_priority();
        test_win();
        test_draw();
        test_win_on_full();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ttt_game_controller.md
Name: ttt_game_controller

Overview:
- Sequencer and sole owner of the 9-cell, 2-bit-per-cell tic-tac-toe game-state memory.
- Clears the board, accepts player moves over a valid/ready handshake and checks that the target cell is empty.
- Writes the mover's mark, rescans all 9 cells to detect win or draw, then alternates turns.
- Sits between the input/button logic and the game-state memory; the VGA renderer consumes its status outputs.

Parameters:
- FIRST_MARK, 2'b01, mark of the player who moves first after a clear.
- TIMEOUT_CYCLES, 250_000_000, idle cycles before the turn is forfeited (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- new_game  in  1  request board clear.
- move_valid  in  1  move request.
- move_addr  in  4  target cell 0..8.
- move_ready  out  1  combinational: state==IDLE && !new_game.
- move_done  out  1  one-cycle pulse: move written and evaluated.
- move_reject  out  1  one-cycle pulse: cell occupied or addr>8.
- turn  out  2  mark of the player to move (01=X, 10=O).
- game_over  out  1  a win or draw has been reached.
- winner  out  2  00 none, 01 X, 10 O, 11 draw.
- busy  out  1  state not IDLE/GAME_OVER.
- mem_r_w  out  1  1 read, 0 write.
- mem_address  out  4  memory cell address.
- mem_wdata  out  2  memory write data.
- mem_rdata  in  2  memory registered read data.

Behaviour:
- Memory timing: read data is registered. Address/r_w driven in cycle N; mem_rdata is valid in cycle N+1. Writes commit at the edge ending the cycle where mem_r_w=0.
- Memory bus defaults: mem_r_w=1, mem_address=0, mem_wdata=0 in every state that does not drive them. No spurious writes.
- Reset (reset=0, async): state=CLEAR, counter=0, turn=FIRST_MARK, winner=00, game_over=0, move_done=0, move_reject=0, busy=1.
- Cell encoding: 00 empty, 01 X, 10 O. 11 is reserved and treated as occupied.
- CLEAR: 9 cycles writing 00 to addresses 0..8, then IDLE. turn=FIRST_MARK, winner=00, game_over=0.
- IDLE:
  - new_game=1 -> CLEAR; it has priority over a simultaneous move_valid, which is not accepted.
  - Otherwise move_valid && move_ready at an edge accepts the move; move_addr is latched.
- RD_CELL (1 cycle): drive the latched address with r_w=1. If address>8, skip to reject.
- CHK_CELL (1 cycle):
  - mem_rdata!=00 -> move_reject=1 in the next cycle, return to IDLE; turn unchanged.
  - Else -> WR_CELL.
- WR_CELL (1 cycle): r_w=0, mem_wdata=turn.
- SCAN (10 cycles): issue reads of addresses 0..8 on consecutive cycles. Capture mem_rdata one cycle later into a 9x2 shadow board.
- EVAL (1 cycle):
  - Check the 8 win lines on the shadow board.
  - Win -> winner=mark, game_over=1, GAME_OVER.
  - Else board full -> winner=11, game_over=1, GAME_OVER.
  - Else toggle turn (01<->10), IDLE.
  - Win has priority over draw on a full board.
- move_done is high for exactly one cycle, 15 cycles after the accept edge (RD 1 + CHK 1 + WR 1 + SCAN 10 + EVAL 1, registered). winner/game_over update in the same cycle.
- GAME_OVER: move_ready=0, and move_valid is ignored. new_game -> CLEAR.
- new_game in states other than IDLE/GAME_OVER is ignored (not latched).
- Reset mid-write or mid-scan: abort immediately to CLEAR. The board is always re-cleared, and the memory's own reset is never relied on.

Optional Feature:
- Macro: TTT_MOVE_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs while in IDLE and clears on any accepted move or on leaving IDLE.
  - When it reaches TIMEOUT_CYCLES-1, turn toggles and the counter clears.
  - A one-cycle pulse on added output timeout_forfeit (out, 1) accompanies the toggle.
  - move_valid on that same cycle wins: the move is accepted, no forfeit.
- Undefined: no counter and no timeout_forfeit port; turn changes only via EVAL/CLEAR.

Decomposition:
- Package ttt_pkg:
  - mark_t enum (EMPTY=00, X=01, O=10).
  - winner encodings.
  - NUM_CELLS=9.
  - WIN_LINES constant: 8x3 cell indices.
  - ctrl_state_t enum (CLEAR, IDLE, RD_CELL, CHK_CELL, WR_CELL, SCAN, EVAL, GAME_OVER).
- Sub-module ttt_win_eval: combinational. Input is the 9x2 shadow board; outputs are win (1), win_mark (2) and full (1).

Test Plan:
- Release reset -> 9 writes of 00 to addresses 0..8, then move_ready=1, turn=01, winner=00.
- X move to 4 on empty board -> write 01 at addr 4; move_done 15 cycles after accept; turn=10.
- O move to 4 (occupied) -> move_reject pulse; no write cycle (mem_r_w stays 1); turn stays 10.
- move_addr=9 -> move_reject pulse; no memory write.
- X plays 0,1,2 with O playing 3,4 -> after 5th move: winner=01, game_over=1, move_ready=0; further move_valid ignored.
- Full board with no line -> winner=11. Then new_game -> CLEAR; assert reset low mid-SCAN -> outputs at reset values, CLEAR sequence restarts.
